memory_dp_be: RTL and testbench



---
 rtl/memory_pkg.sv | 58 +++++
 rtl/memory_rd_pipe.sv | 61 ++++++
 rtl/memory_dp_be.sv | 166 ++++++++++++++++
 tb/tb_memory_dp_be.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memory_pkg
// Brief    : Shared constants, lane-merge helper and parameter check for the
//            byte-enable dual-port memory.
// Revision : 1.0 - initial release
// ============================================================================
package memory_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    // Widest word the merge helper handles; callers zero-extend into it.
    localparam int c_MAX_DATA = 512;
    localparam int c_IDX_W    = $clog2(c_MAX_DATA);

    function automatic logic [c_MAX_DATA-1:0] lane_merge(
        input logic [c_MAX_DATA-1:0] old_word,
        input logic [c_MAX_DATA-1:0] new_word,
        input logic [c_MAX_DATA-1:0] be,
        input int                    lane
    );
        logic [c_MAX_DATA-1:0] merged;
        merged = old_word;
        if (lane > 0) begin
            for (int i = 0; i < c_MAX_DATA; i++) begin
                if (be[c_IDX_W'(i / lane)]) begin
                    merged[i] = new_word[i];
                end
            end
        end
        return merged;
    endfunction

    function automatic bit params_ok(
        input int data,
        input int lane,
        input int rd_lat,
        input int rdw_mode
    );
        bit ok;
        ok = 1'b1;
        if (lane <= 0 || data <= 0 || data >= c_MAX_DATA) begin
            ok = 1'b0;
        end else if ((data % lane) != 0) begin
            ok = 1'b0;
        end
        if (rd_lat != 1 && rd_lat != 2) begin
            ok = 1'b0;
        end
        if (rdw_mode != RDW_WRITE_FIRST && rdw_mode != RDW_READ_FIRST) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : memory_rd_pipe
// Brief    : Per-port read output stage(s): one or two registers with valid;
//            data holds its last value when nothing was accepted.
// Revision : 1.0 - initial release
// ============================================================================
module memory_rd_pipe #(
    parameter int DATA   = 72,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    input  logic [DATA-1:0] i_data,
    output logic [DATA-1:0] o_data,
    output logic            o_valid
);

    logic [DATA-1:0] r_s1_data;
    logic            r_s1_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_data <= i_data;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA-1:0] r_s2_data;
            logic            r_s2_valid;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s2_data  <= '0;
                    r_s2_valid <= 1'b0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign o_data  = r_s2_data;
            assign o_valid = r_s2_valid;
        end else begin : g_lat1
            assign o_data  = r_s1_data;
            assign o_valid = r_s1_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/memory_dp_be.sv
`default_nettype none
// ============================================================================
// Module   : memory_dp_be
// Brief    : True dual-port RAM with lane byte-enables, selectable read
//            latency / read-during-write mode and write collision tracking.
// Revision : 1.0 - initial release
// ============================================================================
module memory_dp_be
    import memory_pkg::*;
#(
    parameter  int DATA     = 72,
    parameter  int ADDR     = 10,
    parameter  int LANE     = 8,
    parameter  int RD_LAT   = 1,
    parameter  int RDW_MODE = 0,
    parameter  int CNT_W    = 16,
    localparam int LANES    = DATA / LANE
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             a_en,
    input  logic             a_wr,
    input  logic [LANES-1:0] a_be,
    input  logic [ADDR-1:0]  a_addr,
    input  logic [DATA-1:0]  a_din,
    output logic [DATA-1:0]  a_dout,
    output logic             a_valid,

    input  logic             b_en,
    input  logic             b_wr,
    input  logic [LANES-1:0] b_be,
    input  logic [ADDR-1:0]  b_addr,
    input  logic [DATA-1:0]  b_din,
    output logic [DATA-1:0]  b_dout,
    output logic             b_valid,

    output logic             collision,
    output logic [CNT_W-1:0] coll_count
);

    localparam int c_DEPTH = 2 ** ADDR;

    generate
        if (!params_ok(DATA, LANE, RD_LAT, RDW_MODE)) begin : g_param_check
            $error("memory_dp_be: illegal DATA/LANE/RD_LAT/RDW_MODE combination");
        end
    endgenerate

    logic [DATA-1:0] mem [c_DEPTH];

    logic w_a_acc;
    logic w_b_acc;
    logic w_a_wr;
    logic w_b_wr;
    logic w_same;
    logic w_coll;

    assign w_a_acc = a_en & ~rst;
    assign w_b_acc = b_en & ~rst;
    assign w_a_wr  = w_a_acc & a_wr;
    assign w_b_wr  = w_b_acc & b_wr;
    assign w_same  = (a_addr == b_addr);
    assign w_coll  = w_a_wr & w_b_wr & w_same;

    logic [c_MAX_DATA-1:0] w_a_old;
    logic [c_MAX_DATA-1:0] w_b_old;
    logic [c_MAX_DATA-1:0] w_a_din;
    logic [c_MAX_DATA-1:0] w_b_din;
    logic [c_MAX_DATA-1:0] w_a_be;
    logic [c_MAX_DATA-1:0] w_b_be;
    logic [c_MAX_DATA-1:0] w_a_tmp;
    logic [c_MAX_DATA-1:0] w_b_tmp;
    logic [c_MAX_DATA-1:0] w_a_fin;
    logic [c_MAX_DATA-1:0] w_b_fin;

    // Final word at each port's address: B's lanes applied first, then A's
    // lanes on top, so A wins wherever both ports enable the same lane.
    always_comb begin
        w_a_old = '0;
        w_b_old = '0;
        w_a_din = '0;
        w_b_din = '0;
        w_a_be  = '0;
        w_b_be  = '0;

        w_a_old[DATA-1:0]  = mem[a_addr];
        w_b_old[DATA-1:0]  = mem[b_addr];
        w_a_din[DATA-1:0]  = a_din;
        w_b_din[DATA-1:0]  = b_din;
        w_a_be[LANES-1:0]  = a_be;
        w_b_be[LANES-1:0]  = b_be;

        w_a_tmp = (w_b_wr && w_same) ? lane_merge(w_a_old, w_b_din, w_b_be, LANE) : w_a_old;
        w_a_fin = w_a_wr ? lane_merge(w_a_tmp, w_a_din, w_a_be, LANE) : w_a_tmp;

        w_b_tmp = w_b_wr ? lane_merge(w_b_old, w_b_din, w_b_be, LANE) : w_b_old;
        w_b_fin = (w_a_wr && w_same) ? lane_merge(w_b_tmp, w_a_din, w_a_be, LANE) : w_b_tmp;
    end

    logic w_unused_hi;
    assign w_unused_hi = ^{w_a_fin[c_MAX_DATA-1:DATA], w_b_fin[c_MAX_DATA-1:DATA]};

    // On a collision A's write already carries the merged word.
    always_ff @(posedge clk) begin
        if (w_a_wr) begin
            mem[a_addr] <= w_a_fin[DATA-1:0];
        end
        if (w_b_wr && !(w_a_wr && w_same)) begin
            mem[b_addr] <= w_b_fin[DATA-1:0];
        end
    end

    logic [DATA-1:0] w_a_rd;
    logic [DATA-1:0] w_b_rd;

    assign w_a_rd = (RDW_MODE == RDW_READ_FIRST) ? w_a_old[DATA-1:0] : w_a_fin[DATA-1:0];
    assign w_b_rd = (RDW_MODE == RDW_READ_FIRST) ? w_b_old[DATA-1:0] : w_b_fin[DATA-1:0];

    memory_rd_pipe #(
        .DATA   (DATA),
        .RD_LAT (RD_LAT)
    ) u_pipe_a (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_a_acc),
        .i_data  (w_a_rd),
        .o_data  (a_dout),
        .o_valid (a_valid)
    );

    memory_rd_pipe #(
        .DATA   (DATA),
        .RD_LAT (RD_LAT)
    ) u_pipe_b (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_b_acc),
        .i_data  (w_b_rd),
        .o_data  (b_dout),
        .o_valid (b_valid)
    );

    logic             r_coll_stage;
    logic             r_collision;
    logic [CNT_W-1:0] r_coll_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_coll_stage <= 1'b0;
            r_collision  <= 1'b0;
            r_coll_count <= '0;
        end else begin
            r_coll_stage <= w_coll;
            r_collision  <= r_coll_stage;
            if (r_coll_stage && (r_coll_count != {CNT_W{1'b1}})) begin
                r_coll_count <= r_coll_count + 1'b1;
            end
        end
    end

    assign collision  = r_collision;
    assign coll_count = r_coll_count;

endmodule
`default_nettype wire

// File: tb/tb_memory_dp_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_dp_be
// Brief    : Directed bench for memory_dp_be: default instance plus a
//            READ_FIRST / RD_LAT=2 / CNT_W=4 instance sharing stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_dp_be;

    localparam logic [71:0] c_ALL = {72{1'b1}};
    localparam logic [71:0] c_W1  = 72'h0123456789ABCDEF01;
    localparam logic [71:0] c_W2  = 72'h0123456789ABCDEFFF;
    localparam logic [71:0] c_AA  = {9{8'hAA}};
    localparam logic [71:0] c_55  = {9{8'h55}};
    localparam logic [71:0] c_33  = {9{8'h33}};
    localparam logic [71:0] c_44  = {9{8'h44}};
    localparam logic [71:0] c_M1  = 72'h5555555555AAAAAAAA;
    localparam logic [71:0] c_M2  = 72'h440000000000003333;
    localparam logic [8:0]  c_BE1 = 9'h1FF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_en = 1'b0, a_wr = 1'b0, b_en = 1'b0, b_wr = 1'b0;
    logic [8:0]  a_be = '0, b_be = '0;
    logic [9:0]  a_addr = '0, b_addr = '0;
    logic [71:0] a_din = '0, b_din = '0;

    logic [71:0] a_dout0, b_dout0, a_dout1, b_dout1;
    logic        a_valid0, b_valid0, a_valid1, b_valid1;
    logic        coll0, coll1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    always #5 clk = ~clk;

    memory_dp_be dut0 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout0), .a_valid(a_valid0),
        .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout0), .b_valid(b_valid0),
        .collision(coll0), .coll_count(cnt0)
    );

    memory_dp_be #(.RD_LAT(2), .RDW_MODE(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout1), .a_valid(a_valid1),
        .b_en(b_en), .b_wr(b_wr), .b_be(b_be), .b_addr(b_addr), .b_din(b_din),
        .b_dout(b_dout1), .b_valid(b_valid1),
        .collision(coll1), .coll_count(cnt1)
    );

    typedef struct {
        logic        a_en, a_wr;
        logic [8:0]  a_be;
        logic [9:0]  a_addr;
        logic [71:0] a_din;
        logic        b_en, b_wr;
        logic [8:0]  b_be;
        logic [9:0]  b_addr;
        logic [71:0] b_din;
        logic        ea_valid;
        logic [71:0] ea_dout;
        logic        eb_valid;
        logic [71:0] eb_dout;
        logic        ecoll;
        logic [15:0] ecnt;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic vec_t mk(
        input logic ae, input logic aw, input logic [8:0] abe, input logic [9:0] aad, input logic [71:0] ad,
        input logic bn, input logic bw, input logic [8:0] bbe, input logic [9:0] bad, input logic [71:0] bd
    );
        vec_t v;
        v = '{ae, aw, abe, aad, ad, bn, bw, bbe, bad, bd, 1'b0, 72'd0, 1'b0, 72'd0, 1'b0, 16'd0};
        return v;
    endfunction

    function automatic vec_t tv(
        input vec_t s, input logic eav, input logic [71:0] ead, input logic ebv, input logic [71:0] ebd,
        input logic ec, input logic [15:0] ecn
    );
        vec_t v;
        v = s;
        v.ea_valid = eav; v.ea_dout = ead;
        v.eb_valid = ebv; v.eb_dout = ebd;
        v.ecoll = ec; v.ecnt = ecn;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        a_en = v.a_en; a_wr = v.a_wr; a_be = v.a_be; a_addr = v.a_addr; a_din = v.a_din;
        b_en = v.b_en; b_wr = v.b_wr; b_be = v.b_be; b_addr = v.b_addr; b_din = v.b_din;
    endtask

    task automatic step(input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
    endtask

    vec_t idle;
    vec_t vecs[17];

    initial begin
        idle = mk(0, 0, 9'h0, 10'd0, 72'd0, 0, 0, 9'h0, 10'd0, 72'd0);

        vecs[0]  = tv(mk(1,1,c_BE1,10'd5,c_W1,    0,0,9'h0,10'd0,72'd0),  1,c_W1,   0,72'd0, 0,16'd0);
        vecs[1]  = tv(mk(1,0,9'h0,10'd5,72'd0,    0,0,9'h0,10'd0,72'd0),  1,c_W1,   0,72'd0, 0,16'd0);
        vecs[2]  = tv(mk(0,0,9'h0,10'd0,72'd0,    1,1,9'h001,10'd5,c_ALL), 0,c_W1,  1,c_W2,  0,16'd0);
        vecs[3]  = tv(mk(1,0,9'h0,10'd5,72'd0,    1,0,9'h0,10'd5,72'd0),  1,c_W2,   1,c_W2,  0,16'd0);
        vecs[4]  = tv(mk(1,1,c_BE1,10'd7,72'h11,  0,0,9'h0,10'd0,72'd0),  1,72'h11, 0,c_W2,  0,16'd0);
        vecs[5]  = tv(mk(1,1,c_BE1,10'd7,72'h22,  1,0,9'h0,10'd7,72'd0),  1,72'h22, 1,72'h22,0,16'd0);
        vecs[6]  = tv(mk(1,1,9'h00F,10'd3,c_AA,   1,1,c_BE1,10'd3,c_55),  1,c_M1,   1,c_M1,  0,16'd0);
        vecs[7]  = tv(mk(1,0,9'h0,10'd3,72'd0,    0,0,9'h0,10'd0,72'd0),  1,c_M1,   0,c_M1,  1,16'd1);
        vecs[8]  = tv(idle,                                               0,c_M1,   0,c_M1,  0,16'd1);
        vecs[9]  = tv(mk(1,1,9'h0,10'd3,72'd0,    1,1,9'h0,10'd5,c_ALL),  1,c_M1,   1,c_W2,  0,16'd1);
        vecs[10] = tv(mk(1,0,9'h0,10'd3,72'd0,    1,0,9'h0,10'd5,72'd0),  1,c_M1,   1,c_W2,  0,16'd1);
        vecs[11] = tv(mk(1,1,c_BE1,10'd20,72'd0,  0,0,9'h0,10'd0,72'd0),  1,72'd0,  0,c_W2,  0,16'd1);
        vecs[12] = tv(mk(1,1,9'h003,10'd20,c_33,  1,1,9'h100,10'd20,c_44), 1,c_M2,  1,c_M2,  0,16'd1);
        vecs[13] = tv(idle,                                               0,c_M2,   0,c_M2,  1,16'd2);
        vecs[14] = tv(mk(1,0,9'h0,10'd20,72'd0,   1,0,9'h0,10'd3,72'd0),  1,c_M2,   1,c_M1,  0,16'd2);
        vecs[15] = tv(mk(1,1,c_BE1,10'd9,c_AA,    1,1,c_BE1,10'd9,c_55),  1,c_AA,   1,c_AA,  0,16'd2);
        vecs[16] = tv(mk(1,0,9'h0,10'd9,72'd0,    1,0,9'h0,10'd9,72'd0),  1,c_AA,   1,c_AA,  1,16'd3);

        // Reset state of both instances.
        #1;
        chk("rst_a_dout0", a_dout0, 72'd0);
        chk("rst_b_dout0", b_dout0, 72'd0);
        chk("rst_a_valid0", 72'(a_valid0), 72'd0);
        chk("rst_b_valid0", 72'(b_valid0), 72'd0);
        chk("rst_coll0", 72'(coll0), 72'd0);
        chk("rst_cnt0", 72'(cnt0), 72'd0);
        chk("rst_a_dout1", a_dout1, 72'd0);
        chk("rst_cnt1", 72'(cnt1), 72'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i]);
            chk($sformatf("v%0d_a_valid", i), 72'(a_valid0), 72'(vecs[i].ea_valid));
            chk($sformatf("v%0d_a_dout", i),  a_dout0,       vecs[i].ea_dout);
            chk($sformatf("v%0d_b_valid", i), 72'(b_valid0), 72'(vecs[i].eb_valid));
            chk($sformatf("v%0d_b_dout", i),  b_dout0,       vecs[i].eb_dout);
            chk($sformatf("v%0d_coll", i),    72'(coll0),    72'(vecs[i].ecoll));
            chk($sformatf("v%0d_cnt", i),     72'(cnt0),     72'(vecs[i].ecnt));
        end
        step(idle);

        // READ_FIRST cross-port on the latency-2 instance (addr 7 holds 0x22).
        step(mk(1,1,c_BE1,10'd7,72'h11, 0,0,9'h0,10'd0,72'd0));
        step(mk(1,1,c_BE1,10'd7,72'h22, 1,0,9'h0,10'd7,72'd0));
        chk("wf_xport_b0", b_dout0, 72'h22);
        chk("rf_write_old_a1", a_dout1, 72'h22);
        chk("rf_write_valid_a1", 72'(a_valid1), 72'd1);
        step(idle);
        chk("rf_xport_b1", b_dout1, 72'h11);
        chk("rf_xport_valid_b1", 72'(b_valid1), 72'd1);
        chk("rf_write2_old_a1", a_dout1, 72'h11);
        step(idle);
        chk("lat2_idle_valid_b1", 72'(b_valid1), 72'd0);
        chk("lat2_hold_b1", b_dout1, 72'h11);

        // Counter clears asynchronously, then saturation with 20 collisions.
        rst = 1'b1;
        #2;
        chk("async_clr_cnt0", 72'(cnt0), 72'd0);
        chk("async_clr_cnt1", 72'(cnt1), 72'd0);
        chk("async_clr_dout1", b_dout1, 72'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step(mk(1,1,c_BE1,10'd3,72'd0, 1,1,c_BE1,10'd3,c_ALL));
            if (k == 3) begin
                chk("b2b_coll0", 72'(coll0), 72'd1);
                chk("b2b_cnt0", 72'(cnt0), 72'd2);
            end
        end
        step(idle);
        chk("sat_cnt0", 72'(cnt0), 72'd20);
        chk("sat_cnt1", 72'(cnt1), 72'd15);
        step(idle);
        chk("sat_coll_end1", 72'(coll1), 72'd0);
        chk("sat_cnt1_hold", 72'(cnt1), 72'd15);

        // RD_LAT=2: four reads, reset asserted before the third edge.
        step(mk(1,0,9'h0,10'd5,72'd0, 0,0,9'h0,10'd0,72'd0));
        chk("lat2_first_pending", 72'(a_valid1), 72'd0);
        step(mk(1,0,9'h0,10'd5,72'd0, 0,0,9'h0,10'd0,72'd0));
        chk("lat2_first_valid", 72'(a_valid1), 72'd1);
        chk("lat2_first_data", a_dout1, c_W2);
        rst = 1'b1;
        #1;
        chk("midrst_valid1", 72'(a_valid1), 72'd0);
        chk("midrst_dout1", a_dout1, 72'd0);
        chk("midrst_cnt1", 72'(cnt1), 72'd0);
        step(mk(1,0,9'h0,10'd5,72'd0, 0,0,9'h0,10'd0,72'd0));
        chk("midrst_r3_valid1", 72'(a_valid1), 72'd0);
        step(mk(1,0,9'h0,10'd5,72'd0, 0,0,9'h0,10'd0,72'd0));
        chk("midrst_r4_valid1", 72'(a_valid1), 72'd0);
        rst = 1'b0;
        step(idle);
        chk("post_rst_valid1_a", 72'(a_valid1), 72'd0);
        step(idle);
        chk("post_rst_valid1_b", 72'(a_valid1), 72'd0);
        chk("post_rst_dout1", a_dout1, 72'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
